// File: rtl/vga_pkg.sv
// Shared types, default timing and colour-widening helpers for the VGA stream output.
package vga_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, RUN, RESYNC} state_t;
  typedef enum logic {RGB565, RGB888} pix_fmt_t;

  localparam int unsigned DEF_HDISP  = 640;
  localparam int unsigned DEF_VDISP  = 480;
  localparam int unsigned DEF_HFP    = 16;
  localparam int unsigned DEF_HPULSE = 96;
  localparam int unsigned DEF_HBP    = 48;
  localparam int unsigned DEF_VFP    = 11;
  localparam int unsigned DEF_VPULSE = 2;
  localparam int unsigned DEF_VBP    = 31;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned COL_W = 10;

  typedef struct packed {
    logic [COL_W-1:0] r;
    logic [COL_W-1:0] g;
    logic [COL_W-1:0] b;
  } rgb10_t;

  // Narrow components are widened by repeating their MSBs into the new LSBs.
  function automatic rgb10_t widen565(input logic [15:0] d);
    rgb10_t c;
    c.r = {d[4:0], d[4:0]};
    c.g = {d[10:5], d[10:7]};
    c.b = {d[15:11], d[15:11]};
    return c;
  endfunction

  function automatic rgb10_t widen888(input logic [23:0] d);
    rgb10_t c;
    c.r = {d[7:0], d[7:6]};
    c.g = {d[15:8], d[15:14]};
    c.b = {d[23:16], d[23:22]};
    return c;
  endfunction

  function automatic rgb10_t widen(input pix_fmt_t fmt, input logic [PIX_W-1:0] d);
    return (fmt == RGB888) ? widen888(d) : widen565(d[15:0]);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with sync, active-region and frame-boundary decode.
module vga_timing #(
  parameter int unsigned HDISP  = 640,
  parameter int unsigned VDISP  = 480,
  parameter int unsigned HFP    = 16,
  parameter int unsigned HPULSE = 96,
  parameter int unsigned HBP    = 48,
  parameter int unsigned VFP    = 11,
  parameter int unsigned VPULSE = 2,
  parameter int unsigned VBP    = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic active_c,
  output logic hs_c,
  output logic vs_c,
  output logic eof_c,
  output logic sof_c
);

  localparam int unsigned HTOT = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOT = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned HW   = $clog2(HTOT);
  localparam int unsigned VW   = $clog2(VTOT);

  logic [HW-1:0] ct_h;
  logic [VW-1:0] ct_v;
  logic          h_last;
  logic          v_last;

  assign h_last = (ct_h == HW'(HTOT - 1));
  assign v_last = (ct_v == VW'(VTOT - 1));

  // Counters sit at the origin whenever the raster is stopped.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      ct_h <= '0;
      ct_v <= '0;
    end else if (h_last) begin
      ct_h <= '0;
      ct_v <= v_last ? '0 : ct_v + VW'(1);
    end else begin
      ct_h <= ct_h + HW'(1);
    end
  end

  assign active_c = (32'(ct_h) < HDISP) && (32'(ct_v) < VDISP);
  assign hs_c     = (32'(ct_h) >= HDISP + HFP) && (32'(ct_h) < HDISP + HFP + HPULSE);
  assign vs_c     = (32'(ct_v) >= VDISP + VFP) && (32'(ct_v) < VDISP + VFP + VPULSE);
  assign eof_c    = h_last && v_last;
  assign sof_c    = (ct_h == '0) && (ct_v == '0);

endmodule

// File: rtl/vga_stream.sv
// Pixel-stream to VGA converter: frame lock FSM, stream handshake and registered colour/sync outputs.
module vga_stream
  import vga_pkg::*;
#(
  parameter int unsigned HDISP  = DEF_HDISP,
  parameter int unsigned VDISP  = DEF_VDISP,
  parameter int unsigned HFP    = DEF_HFP,
  parameter int unsigned HPULSE = DEF_HPULSE,
  parameter int unsigned HBP    = DEF_HBP,
  parameter int unsigned VFP    = DEF_VFP,
  parameter int unsigned VPULSE = DEF_VPULSE,
  parameter int unsigned VBP    = DEF_VBP,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter pix_fmt_t    PIX_FMT = RGB565
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [PIX_W-1:0] S_DATA,
  input  logic             S_VALID,
  input  logic             S_SOF,
  output logic             S_READY,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK,
  output logic             VGA_SYNC,
  output logic [COL_W-1:0] VGA_R,
  output logic [COL_W-1:0] VGA_G,
  output logic [COL_W-1:0] VGA_B,
  output logic             FRAME_START,
  output logic             UNDERFLOW,
  output logic             SOF_ERR
);

  state_t state;
  rgb10_t rgb;
  logic   run;
  logic   active_c;
  logic   hs_c;
  logic   vs_c;
  logic   eof_c;
  logic   sof_c;
  logic   ready_c;

  assign run = EN && (state != IDLE);

  vga_timing #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .HFP   (HFP),
    .HPULSE(HPULSE),
    .HBP   (HBP),
    .VFP   (VFP),
    .VPULSE(VPULSE),
    .VBP   (VBP)
  ) u_timing (
    .clk     (CLK),
    .rst     (RST),
    .run     (run),
    .active_c(active_c),
    .hs_c    (hs_c),
    .vs_c    (vs_c),
    .eof_c   (eof_c),
    .sof_c   (sof_c)
  );

  // While seeking, a SOF beat is left waiting on the bus until the frame boundary.
  always_comb begin
    ready_c = 1'b0;
    if (EN) begin
      case (state)
        SEEK:    ready_c = !active_c && !(S_VALID && S_SOF);
        RUN:     ready_c = active_c;
        default: ready_c = 1'b0;
      endcase
    end
  end

  assign S_READY  = ready_c;
  assign VGA_SYNC = 1'b0;
  assign VGA_R    = rgb.r;
  assign VGA_G    = rgb.g;
  assign VGA_B    = rgb.b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK   <= 1'b0;
      rgb         <= '0;
      FRAME_START <= 1'b0;
      UNDERFLOW   <= 1'b0;
      SOF_ERR     <= 1'b0;
    end else if (!EN) begin
      state       <= IDLE;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK   <= 1'b0;
      rgb         <= '0;
      FRAME_START <= 1'b0;
    end else begin
      VGA_HS      <= hs_c ? HS_POL : ~HS_POL;
      VGA_VS      <= vs_c ? VS_POL : ~VS_POL;
      VGA_BLANK   <= active_c && (state != IDLE);
      rgb         <= '0;
      FRAME_START <= 1'b0;
      case (state)
        IDLE: state <= SEEK;
        SEEK: begin
          if (S_VALID && S_SOF && eof_c) state <= RUN;
        end
        RUN: begin
          FRAME_START <= sof_c;
          if (active_c) begin
            if (!S_VALID) begin
              UNDERFLOW <= 1'b1;
              state     <= RESYNC;
            end else begin
              rgb <= widen(PIX_FMT, S_DATA);
              // A misplaced SOF is still shown; the stream is then re-locked.
              if (S_SOF != sof_c) begin
                SOF_ERR <= 1'b1;
                state   <= RESYNC;
              end
            end
          end
        end
        RESYNC: begin
          if (eof_c) state <= SEEK;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_stream.sv
// Directed bench for vga_stream on an 8x5 raster, one RGB565 and one RGB888 instance sharing stimulus.
module tb_vga_stream;
  import vga_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic [23:0] S_DATA = '0;
  logic        S_VALID = 1'b0;
  logic        S_SOF = 1'b0;

  logic       rdy_a, hs_a, vs_a, blank_a, sync_a, fs_a, uf_a, se_a;
  logic [9:0] r_a, g_a, b_a;
  logic       rdy_b, hs_b, vs_b, blank_b, sync_b, fs_b, uf_b, se_b;
  logic [9:0] r_b, g_b, b_b;

  int n_chk = 0;
  int n_fail = 0;
  int src_idx = 0;
  bit src_valid = 1'b0;
  bit force_sof = 1'b0;

  logic [23:0] tbl [8];
  logic [29:0] e565 [8];
  logic [29:0] e888 [8];

  always #5 CLK = ~CLK;

  vga_stream #(
    .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(2), .HBP(1),
    .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_FMT(RGB565)
  ) dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_SOF(S_SOF),
    .S_READY(rdy_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK(blank_a), .VGA_SYNC(sync_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .FRAME_START(fs_a), .UNDERFLOW(uf_a), .SOF_ERR(se_a)
  );

  vga_stream #(
    .HDISP(4), .VDISP(2), .HFP(1), .HPULSE(2), .HBP(1),
    .VFP(1), .VPULSE(1), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_FMT(RGB888)
  ) dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_SOF(S_SOF),
    .S_READY(rdy_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK(blank_b), .VGA_SYNC(sync_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .FRAME_START(fs_b), .UNDERFLOW(uf_b), .SOF_ERR(se_b)
  );

  task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s p=%0d: observed %h expected %h", tag, p, obs, exp);
    end
  endtask

  // One clock: present the current source beat, count it if taken, settle 1 after the edge.
  task automatic step();
    bit acc;
    S_VALID = src_valid;
    S_DATA  = tbl[src_idx % 8];
    S_SOF   = ((src_idx % 8) == 0) || force_sof;
    #2;
    acc = S_VALID && rdy_a;
    @(posedge CLK);
    if (acc) src_idx++;
    #1;
  endtask

  task automatic chk_reset_out(input string tag);
    chk({tag, "_hs"}, -1, 32'({hs_a, hs_b}), 32'h3);
    chk({tag, "_vs"}, -1, 32'({vs_a, vs_b}), 32'h3);
    chk({tag, "_blank"}, -1, 32'({blank_a, blank_b}), 32'h0);
    chk({tag, "_sync"}, -1, 32'({sync_a, sync_b}), 32'h0);
    chk({tag, "_rgb565"}, -1, 32'({r_a, g_a, b_a}), 32'h0);
    chk({tag, "_rgb888"}, -1, 32'({r_b, g_b, b_b}), 32'h0);
    chk({tag, "_fs"}, -1, 32'({fs_a, fs_b}), 32'h0);
  endtask

  // Runs frame positions 0..stop_p-1; colour is expected up to black_from, black afterwards.
  task automatic frame(input int black_from, input bit fs_on, input int drop_p,
                       input int sof_p, input int stop_p);
    for (int p = 0; p < stop_p; p++) begin
      int h;
      int v;
      bit act;
      h = p % 8;
      v = p / 8;
      act = (h < 4) && (v < 2);
      src_valid = (p != drop_p);
      force_sof = (p == sof_p);
      step();
      chk("hs", p, 32'({hs_a, hs_b}), (h == 5 || h == 6) ? 32'h0 : 32'h3);
      chk("vs", p, 32'({vs_a, vs_b}), (v == 3) ? 32'h0 : 32'h3);
      chk("blank", p, 32'({blank_a, blank_b}), act ? 32'h3 : 32'h0);
      chk("frame_start", p, 32'({fs_a, fs_b}), (fs_on && p == 0) ? 32'h3 : 32'h0);
      chk("rgb565", p, 32'({r_a, g_a, b_a}), (act && p < black_from) ? 32'(e565[v*4+h]) : 32'h0);
      chk("rgb888", p, 32'({r_b, g_b, b_b}), (act && p < black_from) ? 32'(e888[v*4+h]) : 32'h0);
    end
    src_valid = 1'b1;
    force_sof = 1'b0;
  endtask

  initial begin
    tbl[0] = 24'h00F81F; tbl[1] = 24'h0007E0; tbl[2] = 24'h00FF80; tbl[3] = 24'h000001;
    tbl[4] = 24'hFFFFFF; tbl[5] = 24'hFFFFFF; tbl[6] = 24'h000001; tbl[7] = 24'h00F81F;
    e565[0] = {10'h3FF, 10'h000, 10'h3FF}; e888[0] = {10'h07C, 10'h3E3, 10'h000};
    e565[1] = {10'h000, 10'h3FF, 10'h000}; e888[1] = {10'h383, 10'h01C, 10'h000};
    e565[2] = {10'h000, 10'h3CF, 10'h3FF}; e888[2] = {10'h202, 10'h3FF, 10'h000};
    e565[3] = {10'h021, 10'h000, 10'h000}; e888[3] = {10'h004, 10'h000, 10'h000};
    e565[4] = {10'h3FF, 10'h3FF, 10'h3FF}; e888[4] = {10'h3FF, 10'h3FF, 10'h3FF};
    e565[5] = e565[4];                     e888[5] = e888[4];
    e565[6] = e565[3];                     e888[6] = e888[3];
    e565[7] = e565[0];                     e888[7] = e888[0];

    @(posedge CLK);
    #1;

    // Reset and idle
    RST = 1'b1; EN = 1'b0;
    step(); step();
    chk_reset_out("reset");
    chk("reset_flags", -1, 32'({uf_a, se_a, uf_b, se_b}), 32'h0);
    chk("reset_ready", -1, 32'({rdy_a, rdy_b}), 32'h0);
    RST = 1'b0;
    step();
    chk_reset_out("idle");
    chk("idle_ready", -1, 32'({rdy_a, rdy_b}), 32'h0);

    // Lock: three non-SOF beats ahead of the SOF beat
    src_idx = 5; src_valid = 1'b1; EN = 1'b1;
    step();
    chk_reset_out("enable");
    frame(0, 1'b0, -1, -1, 40);
    chk("lock_consumed", -1, 32'(src_idx), 32'd8);

    // Two locked frames: timing, colour, frame start
    frame(40, 1'b1, -1, -1, 40);
    frame(40, 1'b1, -1, -1, 40);
    chk("run_consumed", -1, 32'(src_idx), 32'd24);
    chk("run_flags", -1, 32'({uf_a, se_a}), 32'h0);

    // Underflow at pixel (2,1), then relock
    frame(10, 1'b1, 10, -1, 40);
    chk("uf_flags", -1, 32'({uf_a, se_a, uf_b, se_b}), 32'b1010);
    chk("uf_consumed", -1, 32'(src_idx), 32'd30);
    frame(0, 1'b0, -1, -1, 40);
    chk("uf_seek_consumed", -1, 32'(src_idx), 32'd32);
    frame(40, 1'b1, -1, -1, 40);
    chk("relock_consumed", -1, 32'(src_idx), 32'd40);

    // SOF mismatch at pixel (1,0)
    frame(2, 1'b1, -1, 1, 40);
    chk("sof_flags", -1, 32'({uf_a, se_a, uf_b, se_b}), 32'b1111);
    chk("sof_consumed", -1, 32'(src_idx), 32'd42);
    frame(0, 1'b0, -1, -1, 40);
    chk("sof_seek_consumed", -1, 32'(src_idx), 32'd48);
    frame(40, 1'b1, -1, -1, 40);
    chk("sof_relock_consumed", -1, 32'(src_idx), 32'd56);

    // Enable dropped mid-frame at (3,1)
    frame(40, 1'b1, -1, -1, 11);
    EN = 1'b0;
    step();
    chk_reset_out("en_off");
    chk("en_off_flags", -1, 32'({uf_a, se_a, uf_b, se_b}), 32'b1111);
    chk("en_off_ready", -1, 32'({rdy_a, rdy_b}), 32'h0);
    chk("en_off_consumed", -1, 32'(src_idx), 32'd63);
    step();
    chk_reset_out("en_off_idle");
    EN = 1'b1;
    step();
    chk_reset_out("re_enable");
    frame(0, 1'b0, -1, -1, 40);
    chk("re_enable_consumed", -1, 32'(src_idx), 32'd64);

    // Reset asserted at (3,1) of a running frame
    frame(40, 1'b1, -1, -1, 11);
    RST = 1'b1;
    step();
    chk_reset_out("mid_reset");
    chk("mid_reset_flags", -1, 32'({uf_a, se_a, uf_b, se_b}), 32'h0);
    chk("mid_reset_ready", -1, 32'({rdy_a, rdy_b}), 32'h0);
    RST = 1'b0;
    step();
    chk_reset_out("post_reset_idle");
    frame(0, 1'b0, -1, -1, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_stream.md
VGA_STREAM -- requirements
Module: vga_stream

Interface
REQ-001 Parameters (name, default, meaning): HDISP 640 active pixels/line; VDISP 480 active lines; HFP 16, HPULSE 96, HBP 48 horizontal porches/sync in pixels; VFP 11, VPULSE 2, VBP 31 vertical porches/sync in lines; HS_POL 0 and VS_POL 0 sync active level; PIX_FMT 0 (0=RGB565, 1=RGB888).
REQ-002 Ports (name direction width meaning): CLK in 1 pixel clock; RST in 1 reset; EN in 1 run enable; S_DATA in 24 pixel data; S_VALID in 1 beat valid; S_SOF in 1 beat is pixel (0,0); S_READY out 1 beat accepted; VGA_HS out 1; VGA_VS out 1; VGA_BLANK out 1 (1 = active video); VGA_SYNC out 1 (tied 0); VGA_R, VGA_G, VGA_B out 10 each; FRAME_START out 1 one-cycle pulse; UNDERFLOW out 1 sticky error; SOF_ERR out 1 sticky error.
REQ-003 One clock, CLK; reset RST is synchronous and active-high.

Function
REQ-004 Counters: ctH wraps at HTOT-1 = HDISP+HFP+HPULSE+HBP-1; ctV increments at ctH wrap and wraps at VTOT-1 = VDISP+VFP+VPULSE+VBP-1; widths $clog2(HTOT), $clog2(VTOT).
REQ-005 Active region: ctH<HDISP and ctV<VDISP; HS asserted for HDISP+HFP <= ctH < HDISP+HFP+HPULSE; VS asserted for VDISP+VFP <= ctV < VDISP+VFP+VPULSE; asserted level = HS_POL/VS_POL, otherwise its inverse.
REQ-006 All VGA_* outputs registered from the same counter cycle: one-cycle latency, syncs, BLANK and colour mutually aligned.
REQ-007 FSM states IDLE, SEEK, RUN, RESYNC.
REQ-008 IDLE: counters held at 0, S_READY=0, outputs at reset values; EN=1 -> SEEK.
REQ-009 SEEK: counters run; S_READY=1 only while the counters are outside the active region; beats without S_SOF are discarded; a beat with S_SOF is held (not accepted; S_READY forced 0) until ctH=HTOT-1 and ctV=VTOT-1, then -> RUN.
REQ-010 RUN: S_READY=1 exactly in the active region; an accepted beat drives colour on the next cycle.
REQ-011 Underflow: active pixel with S_VALID=0 -> black pixel, UNDERFLOW set, -> RESYNC.
REQ-012 SOF mismatch: in RUN, accepted beat with S_SOF=1 at other than (0,0), or S_SOF=0 at (0,0) -> SOF_ERR set, pixel still displayed, -> RESYNC.
REQ-013 RESYNC: S_READY=0, outputs black, timing keeps running; at ctH=HTOT-1, ctV=VTOT-1 -> SEEK.
REQ-014 EN=0 in any state -> IDLE next cycle; counters cleared; sticky flags kept.
REQ-015 Non-active cycles: colour = 0, BLANK = 0.
REQ-016 RGB565: R=S_DATA[4:0], G=[10:5], B=[15:11]; widened by MSB replication: R10={r,r}, G10={g,g[5:2]}, B10={b,b}.
REQ-017 RGB888: R=[7:0], G=[15:8], B=[23:16]; 10-bit value = {x,x[7:6]}; unused S_DATA bits ignored.
REQ-018 FRAME_START pulses for one cycle on the output cycle that corresponds to counter (0,0) while in RUN.
REQ-019 UNDERFLOW and SOF_ERR cleared only by RST.

Reset
REQ-020 RST: state IDLE, ctH=ctV=0, S_READY=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK=0, VGA_SYNC=0, colour 0, FRAME_START=0, UNDERFLOW=0, SOF_ERR=0.
REQ-021 RST asserted mid-frame takes priority over all events; recovery always goes through IDLE.

Structure
REQ-022 Shared package vga_pkg: state enum, pix_fmt_t enum (RGB565, RGB888), default timing constants, colour-widening functions.
REQ-023 Single sub-module vga_timing: counters, HS/VS/active decode, end-of-frame flag; vga_stream contains the FSM, stream handshake and colour pipeline.

Verification (test params HDISP=4 VDISP=2 HFP=1 HPULSE=2 HBP=1 VFP=1 VPULSE=1 VBP=1: HTOT=8, VTOT=5, 40 cycles/frame)
REQ-024 Timing: EN=1, continuous valid stream -> HS low at ctH 5-6, VS low on line 3, BLANK high for 4 cycles on lines 0-1, period 40 cycles.
REQ-025 Lock: non-SOF beats followed by a SOF beat -> non-SOF beats consumed during blanking; SOF pixel shown at (0,0) of the next frame; FRAME_START pulses once.
REQ-026 Colour: RGB565 0xF81F -> R=0x3FF, G=0x000, B=0x3FF; RGB565 0x07E0 -> G=0x3FF; RGB888 0x00FF80 -> R=0x202, G=0x3FF, B=0x000.
REQ-027 Underflow: S_VALID dropped at pixel (2,1) -> that pixel black, UNDERFLOW=1, black until frame end, relock on next SOF.
REQ-028 SOF error: S_SOF=1 at pixel (1,0) -> SOF_ERR=1, RESYNC then SEEK.
REQ-029 Reset/enable: RST at ctH=3, ctV=1 -> all outputs at reset values next cycle; EN=0 mid-frame -> IDLE, flags preserved.
